// File: rtl/sar_pkg.sv
// Shared types and default parameters for the SAR ADC conversion sequencer.
package sar_pkg;

    localparam int NBIT_DEF    = 10;
    localparam int SMP_CYC_DEF = 3;
    localparam int TO_CYC_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } sar_state_t;

    typedef logic [NBIT_DEF-1:0] dac_t;

endpackage

// File: rtl/sar_seq_if.sv
// Handshake bundle between the SAR sequencer (slave) and its analog front end / back end (master).
interface sar_seq_if import sar_pkg::*; #(parameter int NBIT = NBIT_DEF) ();

    logic            START;
    logic            CONT;
    logic            CMP_RDY;
    logic            CMP_OUT;
    logic            SMP;
    logic [NBIT-1:0] DAC;
    logic            CMP_EN;
    logic [NBIT-1:0] DOUT;
    logic            DVAL;
    logic            BUSY;
    logic            TO_ERR;

    modport slave (
        input  START, CONT, CMP_RDY, CMP_OUT,
        output SMP, DAC, CMP_EN, DOUT, DVAL, BUSY, TO_ERR
    );

    modport master (
        output START, CONT, CMP_RDY, CMP_OUT,
        input  SMP, DAC, CMP_EN, DOUT, DVAL, BUSY, TO_ERR
    );

endinterface

// File: rtl/sar_bit_reg.sv
// Successive-approximation register: holds the DAC trial word and the index of the bit under test.
module sar_bit_reg import sar_pkg::*; #(
    parameter int NBIT = NBIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load_msb,
    input  logic            decide,
    input  logic            keep,
    output logic [NBIT-1:0] sar,
    output logic            last
);

    localparam int IW = $clog2(NBIT);
    typedef logic [IW-1:0] idx_t;
    localparam idx_t MSB_IDX  = idx_t'(NBIT - 1);
    localparam idx_t ZERO_IDX = idx_t'(0);

    logic [NBIT-1:0] sar_d, sar_q;
    idx_t            idx_d, idx_q;

    // Next trial word: resolve the current bit and raise the next lower one in the same edge.
    always_comb begin
        sar_d = sar_q;
        idx_d = idx_q;
        if (clear) begin
            sar_d = {NBIT{1'b0}};
            idx_d = ZERO_IDX;
        end else if (load_msb) begin
            sar_d          = {NBIT{1'b0}};
            sar_d[NBIT-1]  = 1'b1;
            idx_d          = MSB_IDX;
        end else if (decide) begin
            for (int b = 0; b < NBIT; b++) begin
                if (int'(idx_q) == b) begin
                    sar_d[b] = keep;
                end else if (int'(idx_q) == b + 1) begin
                    sar_d[b] = 1'b1;
                end else begin
                    sar_d[b] = sar_q[b];
                end
            end
            if (idx_q != ZERO_IDX) begin
                idx_d = idx_q - idx_t'(1);
            end else begin
                idx_d = idx_q;
            end
        end else begin
            sar_d = sar_q;
            idx_d = idx_q;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sar_q <= {NBIT{1'b0}};
            idx_q <= ZERO_IDX;
        end else begin
            sar_q <= sar_d;
            idx_q <= idx_d;
        end
    end

    assign sar  = sar_q;
    assign last = (idx_q == ZERO_IDX);

endmodule

// File: rtl/sar_seq.sv
// SAR ADC conversion sequencer: sample phase, per-bit settle/compare with timeout, registered result.
module sar_seq import sar_pkg::*; #(
    parameter int NBIT    = NBIT_DEF,
    parameter int SMP_CYC = SMP_CYC_DEF,
    parameter int TO_CYC  = TO_CYC_DEF
) (
    input  logic      CK,
    input  logic      RST,
    sar_seq_if.slave  bus
);

    localparam int SCW = $clog2(SMP_CYC + 1);
    localparam int TCW = $clog2(TO_CYC + 1);
    localparam logic [SCW-1:0] SMP_LAST = SCW'(SMP_CYC - 1);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(TO_CYC - 1);

    sar_state_t      state_d, state_q;
    logic [SCW-1:0]  smp_cnt_d, smp_cnt_q;
    logic [TCW-1:0]  to_cnt_d, to_cnt_q;
    logic            smp_d, smp_q;
    logic            cmp_en_d, cmp_en_q;
    logic [NBIT-1:0] dout_d, dout_q;
    logic            dval_d, dval_q;
    logic            busy_d, busy_q;
    logic            to_err_d, to_err_q;

    logic            bit_clear, bit_load, bit_decide, bit_keep, bit_last;
    logic [NBIT-1:0] dac_word;

    sar_bit_reg #(.NBIT(NBIT)) u_bit_reg (
        .clk      (CK),
        .rst      (RST),
        .clear    (bit_clear),
        .load_msb (bit_load),
        .decide   (bit_decide),
        .keep     (bit_keep),
        .sar      (dac_word),
        .last     (bit_last)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        to_cnt_d   = to_cnt_q;
        smp_d      = 1'b0;
        cmp_en_d   = 1'b0;
        dout_d     = dout_q;
        dval_d     = 1'b0;
        to_err_d   = to_err_q;
        bit_clear  = 1'b0;
        bit_load   = 1'b0;
        bit_decide = 1'b0;
        bit_keep   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d   = ST_SAMPLE;
                    smp_d     = 1'b1;
                    smp_cnt_d = {SCW{1'b0}};
                    to_err_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (smp_cnt_q == SMP_LAST) begin
                    state_d  = ST_SETTLE;
                    bit_load = 1'b1;
                end else begin
                    smp_cnt_d = smp_cnt_q + SCW'(1);
                    smp_d     = 1'b1;
                end
            end
            ST_SETTLE: begin
                state_d  = ST_COMPARE;
                cmp_en_d = 1'b1;
                to_cnt_d = {TCW{1'b0}};
            end
            ST_COMPARE: begin
                // A missing comparator answer resolves the bit as 0 and is remembered in TO_ERR.
                if (bus.CMP_RDY || (to_cnt_q == TO_LAST)) begin
                    bit_decide = 1'b1;
                    bit_keep   = bus.CMP_RDY & bus.CMP_OUT;
                    if (!bus.CMP_RDY) begin
                        to_err_d = 1'b1;
                    end else begin
                        to_err_d = to_err_q;
                    end
                    if (bit_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                    cmp_en_d = 1'b1;
                end
            end
            ST_DONE: begin
                dout_d    = dac_word;
                dval_d    = 1'b1;
                bit_clear = 1'b1;
                if (bus.CONT) begin
                    state_d   = ST_SAMPLE;
                    smp_d     = 1'b1;
                    smp_cnt_d = {SCW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_clear = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            smp_cnt_q <= {SCW{1'b0}};
            to_cnt_q  <= {TCW{1'b0}};
            smp_q     <= 1'b0;
            cmp_en_q  <= 1'b0;
            dout_q    <= {NBIT{1'b0}};
            dval_q    <= 1'b0;
            busy_q    <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            to_cnt_q  <= to_cnt_d;
            smp_q     <= smp_d;
            cmp_en_q  <= cmp_en_d;
            dout_q    <= dout_d;
            dval_q    <= dval_d;
            busy_q    <= busy_d;
            to_err_q  <= to_err_d;
        end
    end

    assign bus.SMP    = smp_q;
    assign bus.DAC    = dac_word;
    assign bus.CMP_EN = cmp_en_q;
    assign bus.DOUT   = dout_q;
    assign bus.DVAL   = dval_q;
    assign bus.BUSY   = busy_q;
    assign bus.TO_ERR = to_err_q;

endmodule

// File: tb/tb_sar_seq.sv
// Self-checking bench for sar_seq: comparator model plus a bit-serial reference of the conversion.
module tb_sar_seq;
    import sar_pkg::*;

    localparam int NB = NBIT_DEF;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dac_t rsp_code = '0;
    int   rsp_wait = 0;
    int   wcnt     = 0;

    sar_seq_if #(.NBIT(NB)) bus ();

    sar_seq dut (.CK(clk), .RST(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Comparator: answers after rsp_wait COMPARE cycles; garbage outside COMPARE.
    always @(negedge clk) begin
        if (bus.CMP_EN) begin
            wcnt = wcnt + 1;
            if (wcnt > rsp_wait) begin
                bus.CMP_RDY = 1'b1;
                bus.CMP_OUT = (rsp_code >= bus.DAC);
            end else begin
                bus.CMP_RDY = 1'b0;
                bus.CMP_OUT = 1'($urandom);
            end
        end else begin
            wcnt = 0;
            bus.CMP_RDY = 1'($urandom);
            bus.CMP_OUT = 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(bus.SMP && bus.CMP_EN)) else begin
                errors++;
                $error("FAIL smp_vs_cmp_en: observed SMP=%0b CMP_EN=%0b expected not both", bus.SMP, bus.CMP_EN);
            end
        end
    end

    task automatic kick();
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    // Call at the negedge right after the edge that entered SAMPLE; returns at the DVAL negedge.
    task automatic measure(input string tag, input dac_t code, input int wt,
                           input bit to_in, input bit chk_clr, input bit poke_start);
        dac_t exp_trials[$];
        dac_t got_trials[$];
        dac_t res = '0;
        dac_t trial;
        bit   any_to = 1'b0;
        int   exp_lat = SMP_CYC_DEF + 1;
        int   exp_ce  = 0;
        int   w;
        int   k = 0, smp_n = 0, ce_n = 0;
        logic prev_ce = 1'b0;
        for (int i = NB - 1; i >= 0; i--) begin
            trial = res | dac_t'(1 << i);
            exp_trials.push_back(trial);
            if (wt >= TO_CYC_DEF) begin
                any_to = 1'b1;
                w = TO_CYC_DEF - 1;
            end else begin
                w = wt;
                if (code >= trial) res = trial;
            end
            exp_lat += 2 + w;
            exp_ce  += 1 + w;
        end
        while (!(bus.DVAL && k > 0) && k < 400) begin
            if (k == 0 && chk_clr) check({tag, "_to_err_cleared"}, 32'(bus.TO_ERR), 32'd0);
            if (bus.SMP) smp_n++;
            if (bus.CMP_EN) ce_n++;
            if (bus.CMP_EN && !prev_ce) got_trials.push_back(bus.DAC);
            prev_ce = bus.CMP_EN;
            if (poke_start && k == 5) bus.START = 1'b1;
            if (poke_start && k == 6) bus.START = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_dout"}, 32'(bus.DOUT), 32'(res));
        check({tag, "_to_err"}, 32'(bus.TO_ERR), 32'(to_in | any_to));
        check({tag, "_smp_cycles"}, 32'(smp_n), 32'(SMP_CYC_DEF));
        check({tag, "_cmp_en_cycles"}, 32'(ce_n), 32'(exp_ce));
        check({tag, "_trial_count"}, 32'(got_trials.size()), 32'(NB));
        for (int i = 0; i < NB && i < got_trials.size(); i++)
            check({tag, "_trial"}, 32'(got_trials[i]), 32'(exp_trials[i]));
    endtask

    task automatic settle_idle(input string tag, input dac_t dout_exp);
        @(negedge clk);
        check({tag, "_dval_pulse"}, 32'(bus.DVAL), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_idle_dac"}, 32'(bus.DAC), 32'd0);
        check({tag, "_dout_hold"}, 32'(bus.DOUT), 32'(dout_exp));
    endtask

    task automatic convert(input string tag, input dac_t code, input int wt, input dac_t dout_exp);
        rsp_code = code;
        rsp_wait = wt;
        kick();
        measure(tag, code, wt, 1'b0, 1'b1, 1'b0);
        settle_idle(tag, dout_exp);
    endtask

    initial begin
        dac_t c;
        int   w;
        int   n, rises;
        logic prev;
        rst = 1'b1;
        bus.START = 1'b0;
        bus.CONT  = 1'b0;
        bus.CMP_RDY = 1'b0;
        bus.CMP_OUT = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_smp", 32'(bus.SMP), 32'd0);
        check("rst_dac", 32'(bus.DAC), 32'd0);
        check("rst_cmp_en", 32'(bus.CMP_EN), 32'd0);
        check("rst_dout", 32'(bus.DOUT), 32'd0);
        check("rst_dval", 32'(bus.DVAL), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_to_err", 32'(bus.TO_ERR), 32'd0);

        convert("c2a5", 10'h2A5, 0, 10'h2A5);
        convert("c3ff", 10'h3FF, 0, 10'h3FF);
        convert("c000", 10'h000, 0, 10'h000);
        convert("c155_w3", 10'h155, 3, 10'h155);
        convert("timeout", 10'h155, 1000, 10'h000);
        convert("after_to", 10'h1C3, 0, 10'h1C3);

        // Back-to-back conversions; a START while busy must be dropped.
        bus.CONT = 1'b1;
        rsp_code = 10'h0A0;
        rsp_wait = 0;
        kick();
        measure("cont1", 10'h0A0, 0, 1'b0, 1'b1, 1'b0);
        bus.CONT = 1'b0;
        rsp_code = 10'h35F;
        check("cont_sample_follows", 32'(bus.SMP), 32'd1);
        measure("cont2", 10'h35F, 0, 1'b0, 1'b0, 1'b1);
        settle_idle("cont2", 10'h35F);
        repeat (3) @(negedge clk);
        check("start_not_queued", 32'(bus.BUSY), 32'd0);

        for (int r = 0; r < 8; r++) begin
            c = dac_t'($urandom_range(0, 1023));
            w = ($urandom_range(0, 4) == 4) ? TO_CYC_DEF + 1 : int'($urandom_range(0, 3));
            convert($sformatf("rnd%0d", r), c, w, (w >= TO_CYC_DEF) ? 10'h000 : c);
        end

        convert("pre_rst", 10'h2C7, 0, 10'h2C7);
        rsp_code = 10'h3A9;
        rsp_wait = 2;
        kick();
        rises = 0;
        prev  = 1'b0;
        n     = 0;
        while (rises < 5 && n < 300) begin
            if (bus.CMP_EN && !prev) rises++;
            prev = bus.CMP_EN;
            if (rises < 5) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_reached_bit5", 32'(rises), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_smp", 32'(bus.SMP), 32'd0);
        check("mid_dac", 32'(bus.DAC), 32'd0);
        check("mid_busy", 32'(bus.BUSY), 32'd0);
        check("mid_dout", 32'(bus.DOUT), 32'd0);
        check("mid_cmp_en", 32'(bus.CMP_EN), 32'd0);
        repeat (2) @(negedge clk);
        check("mid_stays_idle", 32'(bus.BUSY), 32'd0);
        convert("post_rst", 10'h3A9, 0, 10'h3A9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
